// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder slice, a carry flop and shift registers.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             o_ovf,
`endif
  output logic             o_cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic w_s;
  logic w_cout;

  full_adder u_slice (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would chain shifts within one edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a_sh  <= i_a;
            r_b_sh  <= i_b;
            r_carry <= i_cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res   <= {w_s, r_res[WIDTH-1:1]};
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_cout;
          if (r_cnt == LAST) begin
            // r_carry here is the carry into the MSB slice.
            r_sum   <= {w_s, r_res[WIDTH-1:1]};
            r_cout  <= w_cout;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= r_carry ^ w_cout;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign o_ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8) with hand-computed results.
// Defining SERIAL_ADDER_OVF_EN also exercises the overflow output.

module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .o_ovf   (ovf),
`endif
    .o_cout  (cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one addition, scramble the operand inputs after sampling, and
  // return how many cycles until done plus how many of those had busy high.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        output int lat, output int nbusy);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = ~va; b = ~vb; cin = ~vc;
    lat = 0; nbusy = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic add_check(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic vc, input logic [7:0] es, input logic ec);
    int lat, nb;
    run_op(va, vb, vc, lat, nb);
    check({tag, "_latency"}, lat, 9);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
  endtask

  initial begin
    int lat, nb, ndone;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 0);

    run_op(8'h5A, 8'h3C, 1'b0, lat, nb);
    check("basic_latency", lat, 9);
    check("basic_busy_cycles", nb, 8);
    check("basic_sum", sum, 8'h96);
    check("basic_cout", cout, 0);
    @(negedge clk);
    check("basic_done_pulse_width", done, 0);
    check("basic_sum_hold", sum, 8'h96);

    add_check("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    add_check("ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    add_check("00_00_c1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    add_check("a5_5b", 8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 3) begin
        a = 8'hAA; b = 8'h55; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        check("busy_start_sum", sum, 8'h30);
        check("busy_start_cout", cout, 0);
      end
    end
    check("busy_start_done_count", ndone, 1);

    // reset during RUN aborts without done
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 8'h00);
    check("abort_cout", cout, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    add_check("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_ADDER_OVF_EN
    add_check("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    check("ovf_7f_01_ovf", ovf, 1);
    add_check("ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    check("ovf_80_80_ovf", ovf, 1);
    add_check("ovf_40_20", 8'h40, 8'h20, 1'b0, 8'h60, 1'b0);
    check("ovf_40_20_ovf", ovf, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
